// File: rtl/t_excitation_decoder.sv
// T excitation decoder: recovers T = Q(n) ^ Q(n-1) from a sampled Q stream,
// packs bits LSB-first into words and queues them in a 2-entry buffer.
module t_excitation_decoder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       q_in,
  input  logic                       q_valid,
  input  logic                       flush,
  output logic [WIDTH-1:0]           t_word,
  output logic [$clog2(WIDTH+1)-1:0] t_bits,
  output logic                       t_valid,
  input  logic                       t_ready,
  output logic [CNT_W-1:0]           toggle_cnt,
  output logic                       overflow
);

  localparam int BW = $clog2(WIDTH+1);

  logic             q_prev;
  logic [BW-1:0]    bit_cnt;
  logic [BW-1:0]    cnt_eff;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_n;
  logic [WIDTH-1:0] mem_w [2];
  logic [BW-1:0]    mem_b [2];
  logic             rd;
  logic             wr;
  logic [1:0]       fcnt;
  logic             t;
  logic             done;
  logic             push;
  logic             pop;
  logic             full;
  logic             wr_ok;

  always_comb begin
    t       = q_in ^ q_prev;
    cnt_eff = bit_cnt + {{(BW-1){1'b0}}, q_valid};
    sh_n    = sh;
    if (q_valid) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (BW'(i) == bit_cnt) sh_n[i] = t;
      end
    end
    done  = q_valid && (bit_cnt == BW'(WIDTH-1));
    push  = done || (flush && (cnt_eff != '0));
    full  = (fcnt == 2'd2);
    pop   = (fcnt != 2'd0) && t_ready;
    // A full buffer still takes a push when the head leaves this cycle
    wr_ok = push && (!full || pop);
    wr    = rd ^ fcnt[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_prev     <= 1'b0;
      bit_cnt    <= '0;
      sh         <= '0;
      rd         <= 1'b0;
      fcnt       <= 2'd0;
      toggle_cnt <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_w[i] <= '0;
        mem_b[i] <= '0;
      end
    end else begin
      if (q_valid) q_prev <= q_in;
      if (q_valid && t && (toggle_cnt != '1))
        toggle_cnt <= toggle_cnt + CNT_W'(1);
      if (push) begin
        bit_cnt <= '0;
        sh      <= '0;
      end else if (q_valid) begin
        bit_cnt <= cnt_eff;
        sh      <= sh_n;
      end
      if (wr_ok) begin
        mem_w[wr] <= sh_n;
        mem_b[wr] <= cnt_eff;
      end
      if (push && !wr_ok) overflow <= 1'b1;
      if (pop) rd <= ~rd;
      unique case ({wr_ok, pop})
        2'b10:   fcnt <= fcnt + 2'd1;
        2'b01:   fcnt <= fcnt - 2'd1;
        default: fcnt <= fcnt;
      endcase
    end
  end

  assign t_valid = (fcnt != 2'd0);
  assign t_word  = t_valid ? mem_w[rd] : '0;
  assign t_bits  = t_valid ? mem_b[rd] : '0;

endmodule
